// File: rtl/decode_stage_param.sv
// Parametrised instruction decode stage: field decode, register file with
// writeback bypass, load-use interlock and a registered ID/EX slot with
// valid/ready handshaking and flush.
module decode_stage_param #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREGS    = 16,
  parameter  int unsigned IMM_BITS = 14,
  parameter  int unsigned BR_BITS  = 26,
  localparam int unsigned REG_BITS = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  input  logic                flush,
  input  logic                WE,
  input  logic [REG_BITS-1:0] Rd,
  input  logic [XLEN-1:0]     WD,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_ctrl,
  output logic [3:0]          out_opcode,
  output logic [REG_BITS-1:0] out_ra,
  output logic [REG_BITS-1:0] out_rb,
  output logic [REG_BITS-1:0] out_rd,
  output logic [XLEN-1:0]     out_rd1,
  output logic [XLEN-1:0]     out_rd2,
  output logic [XLEN-1:0]     out_imm
);

  localparam int unsigned RD_LSB = 26 - REG_BITS;
  localparam int unsigned RA_LSB = 26 - 2 * REG_BITS;
  localparam int unsigned RB_LSB = 26 - 3 * REG_BITS;

  localparam logic [1:0] TYPE_ALU_REG = 2'b00;
  localparam logic [1:0] TYPE_ALU_IMM = 2'b01;
  localparam logic [1:0] TYPE_MEM     = 2'b10;
  localparam logic [1:0] TYPE_BRANCH  = 2'b11;

  // ctrl = {is_branch, uses_imm, is_mem, mem_load, reg_write}
  localparam logic [4:0] CTRL_ALU_REG = 5'b00001;
  localparam logic [4:0] CTRL_ALU_IMM = 5'b01001;
  localparam logic [4:0] CTRL_LOAD    = 5'b00111;
  localparam logic [4:0] CTRL_STORE   = 5'b00100;
  localparam logic [4:0] CTRL_BRANCH  = 5'b10000;

  // Register file storage
  logic [XLEN-1:0] rf_q [NREGS];

  // Decoded fields of the incoming instruction
  logic [1:0]          type_c;
  logic [3:0]          opcode_c;
  logic [REG_BITS-1:0] rd_c;
  logic [REG_BITS-1:0] ra_c;
  logic [REG_BITS-1:0] rb_c;
  logic [XLEN-1:0]     imm_ext_c;
  logic [XLEN-1:0]     br_ext_c;
  logic [XLEN-1:0]     imm_c;
  logic [4:0]          ctrl_c;
  logic [XLEN-1:0]     rd1_c;
  logic [XLEN-1:0]     rd2_c;
  logic                uses_ra_c;
  logic                uses_rb_c;
  logic                hazard_c;
  logic                slot_free_c;
  logic                accept_c;

  // ID/EX slot
  logic                valid_q,  valid_d;
  logic [4:0]          ctrl_q,   ctrl_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [REG_BITS-1:0] ra_q,     ra_d;
  logic [REG_BITS-1:0] rb_q,     rb_d;
  logic [REG_BITS-1:0] rd_q,     rd_d;
  logic [XLEN-1:0]     rd1_q,    rd1_d;
  logic [XLEN-1:0]     rd2_q,    rd2_d;
  logic [XLEN-1:0]     imm_q,    imm_d;

  assign type_c    = inst[31:30];
  assign opcode_c  = inst[29:26];
  assign rd_c      = inst[RD_LSB +: REG_BITS];
  assign ra_c      = inst[RA_LSB +: REG_BITS];
  assign rb_c      = inst[RB_LSB +: REG_BITS];
  assign imm_ext_c = {{(XLEN - IMM_BITS){inst[IMM_BITS-1]}}, inst[IMM_BITS-1:0]};
  assign br_ext_c  = {{(XLEN - BR_BITS){inst[BR_BITS-1]}}, inst[BR_BITS-1:0]};
  assign imm_c     = (type_c == TYPE_BRANCH) ? br_ext_c : imm_ext_c;

  // Control word and operand-usage flags per instruction type
  always_comb begin
    ctrl_c    = 5'b00000;
    uses_ra_c = 1'b1;
    uses_rb_c = 1'b1;
    case (type_c)
      TYPE_ALU_REG: ctrl_c = CTRL_ALU_REG;
      TYPE_ALU_IMM: begin
        ctrl_c    = CTRL_ALU_IMM;
        uses_rb_c = 1'b0;
      end
      TYPE_MEM:     ctrl_c = opcode_c[0] ? CTRL_STORE : CTRL_LOAD;
      TYPE_BRANCH: begin
        ctrl_c    = CTRL_BRANCH;
        uses_ra_c = 1'b0;
        uses_rb_c = 1'b0;
      end
      default:      ctrl_c = 5'b00000;
    endcase
    // The all-zero word is a NOP with no control effects
    if (inst == 32'h0000_0000) begin
      ctrl_c = 5'b00000;
    end
  end

  // Operand read with same-cycle writeback bypass; register 0 is hardwired zero
  always_comb begin
    rd1_c = rf_q[ra_c];
    rd2_c = rf_q[rb_c];
    if (ra_c == '0) begin
      rd1_c = '0;
    end else if (WE && (Rd == ra_c)) begin
      rd1_c = WD;
    end
    if (rb_c == '0) begin
      rd2_c = '0;
    end else if (WE && (Rd == rb_c)) begin
      rd2_c = WD;
    end
  end

  // Load-use interlock and handshake
  always_comb begin
    hazard_c = in_valid && valid_q && ctrl_q[1] && (rd_q != '0) &&
               ((uses_ra_c && (ra_c == rd_q)) || (uses_rb_c && (rb_c == rd_q)));
    slot_free_c = !valid_q || out_ready;
    in_ready    = slot_free_c && !hazard_c && !flush;
    accept_c    = in_valid && in_ready;
  end

  // Next slot contents: flush clears, stall holds, otherwise load or bubble
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    if (flush || (slot_free_c && !accept_c)) begin
      valid_d  = 1'b0;
      ctrl_d   = '0;
      opcode_d = '0;
      ra_d     = '0;
      rb_d     = '0;
      rd_d     = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
    end else if (accept_c) begin
      valid_d  = 1'b1;
      ctrl_d   = ctrl_c;
      opcode_d = opcode_c;
      ra_d     = ra_c;
      rb_d     = rb_c;
      rd_d     = rd_c;
      rd1_d    = rd1_c;
      rd2_d    = rd2_c;
      imm_d    = imm_c;
    end
  end

  // ID/EX slot register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
    end
  end

  // Register file write port; writes proceed through stall and flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (WE && (Rd != '0)) begin
      rf_q[Rd] <= WD;
    end
  end

  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign out_opcode = opcode_q;
  assign out_ra     = ra_q;
  assign out_rb     = rb_q;
  assign out_rd     = rd_q;
  assign out_rd1    = rd1_q;
  assign out_rd2    = rd2_q;
  assign out_imm    = imm_q;

endmodule

// File: tb/tb_decode_stage_param.sv
// Bench for decode_stage_param: directed and random stimulus on a 32-bit/16-reg
// instance and a 64-bit/32-reg instance, checked against a behavioural model.
module tb_decode_stage_param;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: XLEN=32, NREGS=16, IMM_BITS=14
  logic        a_in_valid, a_in_ready, a_flush, a_we, a_out_valid, a_out_ready;
  logic [31:0] a_inst, a_wd, a_out_rd1, a_out_rd2, a_out_imm;
  logic [3:0]  a_rd, a_out_opcode, a_out_ra, a_out_rb, a_out_rd;
  logic [4:0]  a_out_ctrl;

  // Instance B: XLEN=64, NREGS=32, IMM_BITS=11
  logic        b_in_valid, b_in_ready, b_flush, b_we, b_out_valid, b_out_ready;
  logic [31:0] b_inst;
  logic [63:0] b_wd, b_out_rd1, b_out_rd2, b_out_imm;
  logic [4:0]  b_rd, b_out_ra, b_out_rb, b_out_rd, b_out_ctrl;
  logic [3:0]  b_out_opcode;

  decode_stage_param #(.XLEN(32), .NREGS(16), .IMM_BITS(14), .BR_BITS(26)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .inst(a_inst),
    .flush(a_flush), .WE(a_we), .Rd(a_rd), .WD(a_wd), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_opcode(a_out_opcode),
    .out_ra(a_out_ra), .out_rb(a_out_rb), .out_rd(a_out_rd), .out_rd1(a_out_rd1),
    .out_rd2(a_out_rd2), .out_imm(a_out_imm)
  );

  decode_stage_param #(.XLEN(64), .NREGS(32), .IMM_BITS(11), .BR_BITS(26)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .inst(b_inst),
    .flush(b_flush), .WE(b_we), .Rd(b_rd), .WD(b_wd), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_opcode(b_out_opcode),
    .out_ra(b_out_ra), .out_rb(b_out_rb), .out_rd(b_out_rd), .out_rd1(b_out_rd1),
    .out_rd2(b_out_rd2), .out_imm(b_out_imm)
  );

  // Behavioural model state
  typedef struct packed {
    logic        v;
    logic [4:0]  ctrl;
    logic [3:0]  opc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
  } slot_t;

  slot_t       ms;
  logic        ms_def;
  logic [63:0] mrf [32];
  int          phase, rbits, ibits, xbits;
  int          checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xmask(input logic [63:0] v);
    return (xbits == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] sext(input logic [31:0] ins, input int w);
    logic [63:0] m, f;
    m = (64'd1 << w) - 64'd1;
    f = 64'(ins) & m;
    if (((f >> (w - 1)) & 64'd1) != 64'd0) f = f | ~m;
    return xmask(f);
  endfunction

  // k = 1 (Rd), 2 (Ra), 3 (Rb), fields packed downward from bit 25
  function automatic logic [4:0] fld(input logic [31:0] ins, input int k);
    return 5'((ins >> (26 - k * rbits)) & ((32'd1 << rbits) - 32'd1));
  endfunction

  function automatic logic [31:0] set_fld(input logic [31:0] ins, input int k, input logic [4:0] val);
    logic [31:0] m, v;
    int sh;
    sh = 26 - k * rbits;
    m  = (32'd1 << rbits) - 32'd1;
    v  = 32'(val) & m;
    return (ins & ~(m << sh)) | (v << sh);
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb, input logic [25:0] low);
    logic [31:0] ins;
    ins = {t, op, low};
    ins = set_fld(ins, 1, rd);
    ins = set_fld(ins, 2, ra);
    ins = set_fld(ins, 3, rb);
    return ins;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] ins;
    if ($urandom_range(0, 9) == 0) return 32'h0;
    ins = $urandom;
    for (int k = 1; k <= 3; k++) ins = set_fld(ins, k, 5'($urandom_range(0, 5)));
    return ins;
  endfunction

  function automatic logic [63:0] opnd(input logic [4:0] r, input logic we, input logic [4:0] wrd,
                                       input logic [63:0] wd);
    if (r == 5'd0) return 64'd0;
    if (we && (wrd == r)) return wd;
    return mrf[r];
  endfunction

  function automatic slot_t decode(input logic [31:0] ins, input logic we, input logic [4:0] wrd,
                                   input logic [63:0] wd);
    slot_t s;
    logic [1:0] t;
    t     = ins[31:30];
    s.v   = 1'b1;
    s.opc = ins[29:26];
    s.rd  = fld(ins, 1);
    s.ra  = fld(ins, 2);
    s.rb  = fld(ins, 3);
    case (t)
      2'd0:    s.ctrl = 5'b00001;
      2'd1:    s.ctrl = 5'b01001;
      2'd2:    s.ctrl = ins[26] ? 5'b00100 : 5'b00111;
      default: s.ctrl = 5'b10000;
    endcase
    if (ins == 32'h0) s.ctrl = 5'b00000;
    s.imm = (t == 2'd3) ? sext(ins, 26) : sext(ins, ibits);
    s.rd1 = opnd(s.ra, we, wrd, wd);
    s.rd2 = opnd(s.rb, we, wrd, wd);
    return s;
  endfunction

  function automatic logic hazard(input logic vld, input logic [31:0] ins);
    logic [1:0] t;
    logic ua, ub;
    t  = ins[31:30];
    ua = (t != 2'd3);
    ub = (t == 2'd0) || (t == 2'd2);
    return vld && ms.v && ms.ctrl[1] && (ms.rd != 5'd0) &&
           ((ua && (fld(ins, 2) == ms.rd)) || (ub && (fld(ins, 3) == ms.rd)));
  endfunction

  task automatic set_inputs(input logic vld, input logic [31:0] ins, input logic we, input logic [4:0] wrd,
                            input logic [63:0] wd, input logic ordy, input logic fl);
    if (phase == 0) begin
      a_in_valid = vld; a_inst = ins; a_we = we; a_rd = 4'(wrd); a_wd = 32'(wd);
      a_out_ready = ordy; a_flush = fl;
    end else begin
      b_in_valid = vld; b_inst = ins; b_we = we; b_rd = wrd; b_wd = wd;
      b_out_ready = ordy; b_flush = fl;
    end
  endtask

  task automatic compare_outputs();
    logic v;
    logic [4:0] ctrl, ra, rb, rd;
    logic [3:0] opc;
    logic [63:0] rd1, rd2, imm;
    if (phase == 0) begin
      v = a_out_valid; ctrl = a_out_ctrl; opc = a_out_opcode;
      ra = 5'(a_out_ra); rb = 5'(a_out_rb); rd = 5'(a_out_rd);
      rd1 = 64'(a_out_rd1); rd2 = 64'(a_out_rd2); imm = 64'(a_out_imm);
    end else begin
      v = b_out_valid; ctrl = b_out_ctrl; opc = b_out_opcode;
      ra = b_out_ra; rb = b_out_rb; rd = b_out_rd;
      rd1 = b_out_rd1; rd2 = b_out_rd2; imm = b_out_imm;
    end
    chk("out_valid", 64'(v), 64'(ms.v));
    if (ms_def) begin
      chk("out_ctrl", 64'(ctrl), 64'(ms.ctrl));
      chk("out_opcode", 64'(opc), 64'(ms.opc));
      chk("out_ra", 64'(ra), 64'(ms.ra));
      chk("out_rb", 64'(rb), 64'(ms.rb));
      chk("out_rd", 64'(rd), 64'(ms.rd));
      chk("out_rd1", rd1, ms.rd1);
      chk("out_rd2", rd2, ms.rd2);
      chk("out_imm", imm, ms.imm);
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, check slot after posedge
  task automatic cycle(input logic vld, input logic [31:0] ins, input logic we, input logic [4:0] wrd_in,
                       input logic [63:0] wd_in, input logic ordy, input logic fl, output logic acc);
    slot_t nxt;
    logic nxt_def, hz, er, obs_rdy;
    logic [4:0] wrd;
    logic [63:0] wd;
    wrd = 5'(32'(wrd_in) & ((32'd1 << rbits) - 32'd1));
    wd  = xmask(wd_in);
    @(negedge clk);
    set_inputs(vld, ins, we, wrd, wd, ordy, fl);
    #1;
    obs_rdy = (phase == 0) ? a_in_ready : b_in_ready;
    hz = hazard(vld, ins);
    er = (!ms.v || ordy) && !hz && !fl;
    chk("in_ready", 64'(obs_rdy), 64'(er));
    acc = vld && er;
    nxt = ms;
    nxt_def = ms_def;
    if (fl) begin
      nxt = '0; nxt_def = 1'b1;
    end else if (!ms.v || ordy) begin
      if (acc) begin
        nxt = decode(ins, we, wrd, wd); nxt_def = 1'b1;
      end else begin
        nxt = '0; nxt_def = hz;
      end
    end
    @(posedge clk);
    #1;
    if (we && (wrd != 5'd0)) mrf[wrd] = wd;
    ms = nxt;
    ms_def = nxt_def;
    compare_outputs();
  endtask

  task automatic model_reset();
    ms = '0;
    ms_def = 1'b1;
    for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
  endtask

  // Asynchronous reset asserted away from any clock edge
  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    set_inputs(1'b0, 32'h0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic random_run(input int n);
    logic pend, vld, fl, acc;
    logic [31:0] pins, ins;
    pend = 1'b0;
    pins = 32'h0;
    repeat (n) begin
      vld = pend ? 1'b1 : ($urandom_range(0, 7) != 0);
      ins = pend ? pins : rand_inst();
      fl  = ($urandom_range(0, 19) == 0);
      cycle(vld, ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0), fl, acc);
      pend = vld && !acc && !fl;
      pins = ins;
    end
  endtask

  initial begin
    logic acc;
    logic [31:0] ld, alu, alu2;
    checks = 0; errors = 0;
    phase = 0; rbits = 4; ibits = 14; xbits = 32;
    model_reset();
    a_in_valid = 0; a_inst = 0; a_flush = 0; a_we = 0; a_rd = 0; a_wd = 0; a_out_ready = 1;
    b_in_valid = 0; b_inst = 0; b_flush = 0; b_we = 0; b_rd = 0; b_wd = 0; b_out_ready = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 compare_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Write r2, then ALU-reg reading it
    cycle(1'b0, 32'h0, 1'b1, 5'd2, 64'h55, 1'b1, 1'b0, acc);
    cycle(1'b1, mk(2'd0, 4'b1000, 5'd1, 5'd2, 5'd10, 26'd0), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_alu_ctrl", 64'(a_out_ctrl), 64'h01);
    chk("tp_alu_rd1", 64'(a_out_rd1), 64'h55);

    // ALU-imm with same-cycle bypass, positive and negative immediates
    cycle(1'b1, mk(2'd1, 4'b0101, 5'd10, 5'd6, 5'd0, 26'd15), 1'b1, 5'd6, 64'd7, 1'b1, 1'b0, acc);
    chk("tp_byp_rd1", 64'(a_out_rd1), 64'd7);
    chk("tp_imm_pos", 64'(a_out_imm), 64'hF);
    cycle(1'b1, mk(2'd1, 4'b0101, 5'd10, 5'd6, 5'd0, 26'h3FFF), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_imm_neg", 64'(a_out_imm), 64'hFFFF_FFFF);

    // Load-use: one bubble, then issue; no bubble when registers differ
    ld   = mk(2'd2, 4'b0000, 5'd4, 5'd1, 5'd0, 26'd0);
    alu  = mk(2'd0, 4'b0001, 5'd3, 5'd4, 5'd5, 26'd0);
    alu2 = mk(2'd0, 4'b0001, 5'd3, 5'd5, 5'd6, 26'd0);
    cycle(1'b1, ld, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_load_ctrl", 64'(a_out_ctrl), 64'h07);
    cycle(1'b1, alu, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_bubble_acc", 64'(acc), 64'd0);
    chk("tp_bubble_valid", 64'(a_out_valid), 64'd0);
    cycle(1'b1, alu, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_issue_valid", 64'(a_out_valid), 64'd1);
    cycle(1'b1, ld, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, alu2, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_nohaz_acc", 64'(acc), 64'd1);

    // Branches
    cycle(1'b1, 32'hD000_001A, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_br_ctrl", 64'(a_out_ctrl), 64'h10);
    chk("tp_br_imm", 64'(a_out_imm), 64'd26);
    cycle(1'b1, 32'hC3FF_FFFF, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_br_neg", 64'(a_out_imm), 64'hFFFF_FFFF);

    // Stall, flush in the second stalled cycle with a register write
    cycle(1'b1, alu2, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, acc);
    chk("tp_stall_imm", 64'(a_out_imm), 64'hFFFF_FFFF);
    cycle(1'b1, alu2, 1'b1, 5'd3, 64'h99, 1'b0, 1'b1, acc);
    chk("tp_flush_valid", 64'(a_out_valid), 64'd0);
    cycle(1'b1, mk(2'd0, 4'd0, 5'd1, 5'd3, 5'd0, 26'd0), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, acc);
    chk("tp_flush_wr", 64'(a_out_rd1), 64'h99);

    random_run(300);

    // Reset mid-stream with a valid slot and nonzero registers
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, mk(2'd0, 4'd3, 5'd1, 5'd2, 5'd3, 26'd0), 1'b1, 5'd2, 64'h1234, 1'b1, 1'b0, acc);
    chk("tp_pre_rst_valid", 64'(a_out_valid), 64'd1);
    mid_reset();
    cycle(1'b1, mk(2'd0, 4'd0, 5'd1, 5'd2, 5'd0, 26'd0), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_rst_r2", 64'(a_out_rd1), 64'd0);
    cycle(1'b1, 32'h0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp_nop_ctrl", 64'(a_out_ctrl), 64'd0);
    chk("tp_nop_valid", 64'(a_out_valid), 64'd1);

    // Wide configuration
    set_inputs(1'b0, 32'h0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    phase = 1; rbits = 5; ibits = 11; xbits = 64;
    mid_reset();
    cycle(1'b0, 32'h0, 1'b1, 5'd19, 64'h8000_0000_0000_0001, 1'b1, 1'b0, acc);
    cycle(1'b1, mk(2'd1, 4'd3, 5'd7, 5'd19, 5'd0, 26'h400), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp64_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FC00);
    chk("tp64_ra", 64'(b_out_ra), 64'd19);
    chk("tp64_rd1", b_out_rd1, 64'h8000_0000_0000_0001);
    cycle(1'b1, 32'hC200_0000, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, acc);
    chk("tp64_br", b_out_imm, 64'hFFFF_FFFF_FE00_0000);
    random_run(250);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
